// File: rtl/tft_window_timing.sv
// Parametrised TFT timing generator: HSYNC/VSYNC/DE, BRAM coordinate issue, latency-aligned RGB, button-movable window mask.
// Optional 1-pixel all-ones ring around the window when TFT_WINDOW_BORDER_EN is defined.
module tft_window_timing #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter int SYNC_POL = 0,
  parameter int COLOR_W  = 8,
  parameter int PIX_LAT  = 2,
  parameter int WIN_W    = 64,
  parameter int WIN_H    = 64,
  parameter int STEP     = 4,
  parameter int DEB_CYC  = 16
) (
  input  logic                                                 CLK,
  input  logic                                                 RESET,
  input  logic [3:0]                                           PushButton,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]         hcnt,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]         vcnt,
  output logic                                                 pix_req,
  input  logic [COLOR_W-1:0]                                   BRAM_R,
  input  logic [COLOR_W-1:0]                                   BRAM_G,
  input  logic [COLOR_W-1:0]                                   BRAM_B,
  output logic                                                 Hsync,
  output logic                                                 Vsync,
  output logic                                                 DE_out,
  output logic [COLOR_W-1:0]                                   R,
  output logic [COLOR_W-1:0]                                   G,
  output logic [COLOR_W-1:0]                                   B,
  output logic [$clog2(H_ACTIVE)-1:0]                          win_x,
  output logic [$clog2(V_ACTIVE)-1:0]                          win_y
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int DW = $clog2(DEB_CYC) + 1;
  localparam int X_MAX = H_ACTIVE - WIN_W;
  localparam int Y_MAX = V_ACTIVE - WIN_H;
  localparam logic SP = (SYNC_POL != 0);
  localparam int F_HS = 0, F_VS = 1, F_ACT = 2, F_IN = 3;

  if (WIN_W > H_ACTIVE) begin : g_bad_win_w
    $error("tft_window_timing: WIN_W must not exceed H_ACTIVE");
  end
  if (WIN_H > V_ACTIVE) begin : g_bad_win_h
    $error("tft_window_timing: WIN_H must not exceed V_ACTIVE");
  end
  if (PIX_LAT < 1 || PIX_LAT > 8) begin : g_bad_lat
    $error("tft_window_timing: PIX_LAT must be in 1..8");
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HW'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  logic [31:0] h32, v32, wx32, wy32;
  logic        hs_raw, vs_raw, active_raw, inside_raw;
  assign h32  = 32'(hcnt);
  assign v32  = 32'(vcnt);
  assign wx32 = 32'(win_x);
  assign wy32 = 32'(win_y);

  assign hs_raw     = (h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw     = (v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC);
  assign active_raw = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
  assign inside_raw = (h32 >= wx32) && (h32 < wx32 + WIN_W) &&
                      (v32 >= wy32) && (v32 < wy32 + WIN_H);
  assign pix_req    = active_raw;

`ifdef TFT_WINDOW_BORDER_EN
  localparam int FW = 5;
  localparam int F_RING = 4;
  logic ring_raw;
  assign ring_raw = inside_raw && ((h32 == wx32) || (h32 == wx32 + WIN_W - 1) ||
                                   (v32 == wy32) || (v32 == wy32 + WIN_H - 1));
  logic [FW-1:0] flags_raw;
  assign flags_raw = {ring_raw, inside_raw, active_raw, vs_raw, hs_raw};
`else
  localparam int FW = 4;
  logic [FW-1:0] flags_raw;
  assign flags_raw = {inside_raw, active_raw, vs_raw, hs_raw};
`endif

  // Flags wait PIX_LAT cycles so they meet the BRAM data for the same pixel.
  logic [FW-1:0] flags_sr [PIX_LAT];
  logic [FW-1:0] flags_d;
  assign flags_d = flags_sr[PIX_LAT-1];

  logic [COLOR_W-1:0] r_next, g_next, b_next;
  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (flags_d[F_ACT] && flags_d[F_IN]) begin
      r_next = BRAM_R;
      g_next = BRAM_G;
      b_next = BRAM_B;
    end
`ifdef TFT_WINDOW_BORDER_EN
    if (flags_d[F_ACT] && flags_d[F_RING]) begin
      r_next = '1;
      g_next = '1;
      b_next = '1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < PIX_LAT; i++) flags_sr[i] <= '0;
      Hsync  <= ~SP;
      Vsync  <= ~SP;
      DE_out <= 1'b0;
      R      <= '0;
      G      <= '0;
      B      <= '0;
    end else begin
      flags_sr[0] <= flags_raw;
      for (int i = 1; i < PIX_LAT; i++) flags_sr[i] <= flags_sr[i-1];
      Hsync  <= flags_d[F_HS] ? SP : ~SP;
      Vsync  <= flags_d[F_VS] ? SP : ~SP;
      DE_out <= flags_d[F_ACT];
      R      <= r_next;
      G      <= g_next;
      B      <= b_next;
    end
  end

  // Buttons: [0] up, [1] down, [2] left, [3] right.
  logic [3:0]    sync1, sync2, deb, rise, pend;
  logic [DW-1:0] stab [4];

  always_comb begin
    rise = '0;
    for (int b = 0; b < 4; b++)
      rise[b] = sync2[b] && !deb[b] && (stab[b] == DW'(DEB_CYC - 1));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int b = 0; b < 4; b++) stab[b] <= '0;
    end else begin
      sync1 <= PushButton;
      sync2 <= sync1;
      for (int b = 0; b < 4; b++) begin
        if (sync2[b] == deb[b]) begin
          stab[b] <= '0;
        end else if (stab[b] == DW'(DEB_CYC - 1)) begin
          deb[b]  <= sync2[b];
          stab[b] <= '0;
        end else begin
          stab[b] <= stab[b] + DW'(1);
        end
      end
    end
  end

  // Moves land only at the first blanking line so a visible frame never sees the window shift.
  logic apply;
  assign apply = (hcnt == '0) && (vcnt == VW'(V_ACTIVE));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend  <= '0;
      win_x <= XW'(X_MAX / 2);
      win_y <= YW'(Y_MAX / 2);
    end else begin
      pend <= (apply ? 4'b0000 : pend) | rise;
      if (apply) begin
        if (pend[2] && !pend[3])
          win_x <= (wx32 < STEP) ? '0 : win_x - XW'(STEP);
        else if (pend[3] && !pend[2])
          win_x <= (wx32 + STEP > X_MAX) ? XW'(X_MAX) : win_x + XW'(STEP);
        if (pend[0] && !pend[1])
          win_y <= (wy32 < STEP) ? '0 : win_y - YW'(STEP);
        else if (pend[1] && !pend[0])
          win_y <= (wy32 + STEP > Y_MAX) ? YW'(Y_MAX) : win_y + YW'(STEP);
      end
    end
  end
endmodule
